// File: rtl/lcd_pkg.sv
// lcd_pkg: shared states, HD44780 command bytes and default bus timing for the LCD arbiter.
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BF_SETUP,
        BF_EN,
        BF_GAP,
        WR_SETUP,
        WR_EN,
        WR_HOLD,
        DONE
    } lcd_state_e;

    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] ENTRY_INC     = 8'h06;
    localparam logic [7:0] DISP_ON_CUR   = 8'h0E;
    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] LINE2_ADDR    = 8'hC0;

    localparam int T_SETUP_DEF    = 4;
    localparam int T_EN_DEF       = 12;
    localparam int T_HOLD_DEF     = 4;
    localparam int BF_TIMEOUT_DEF = 200000;
    localparam int CNT_W_DEF      = 18;

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter that stops at zero; done flags the last cycle of a phase.
module lcd_phase_timer #(
    parameter int W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] cnt_o,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= val_i;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign cnt_o  = cnt_q;
    assign done_o = cnt_q == '0;

endmodule

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: round-robin sharing of one HD44780 bus between two writers,
// with a busy-flag poll before every write and counter-timed RS/RW/E sequencing.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int T_SETUP    = T_SETUP_DEF,
    parameter int T_EN       = T_EN_DEF,
    parameter int T_HOLD     = T_HOLD_DEF,
    parameter int BF_TIMEOUT = BF_TIMEOUT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       lcd_oe,
    output logic [7:0] lcd_dout,
    input  logic [7:0] lcd_din,
    output logic       busy,
    output logic       timeout_err
);

    if (64'(BF_TIMEOUT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bf_timeout_range
        $error("BF_TIMEOUT does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_WRSET = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_LIMIT = CNT_W'(BF_TIMEOUT - 1);

    lcd_state_e       state_q;
    logic             rr_last_q, gnt1_q, rs_q, bf_q;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] poll_q;
    logic             lcd_rs_q, lcd_rw_q, lcd_en_q, lcd_on_q, lcd_oe_q;
    logic [7:0]       lcd_dout_q;
    logic             ack0_q, ack1_q, timeout_q;

    logic             gnt0, tmr_load, tmr_done, poll_hit, go_wr;
    logic [CNT_W-1:0] tmr_val, tmr_cnt;
    logic             din_unused;

    assign din_unused = ^lcd_din[6:0];

    // On a tie the requester that was not served last wins.
    assign gnt0     = req0 & (~req1 | rr_last_q);
    assign poll_hit = poll_q >= LD_LIMIT;
    assign go_wr    = !bf_q || poll_hit;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                tmr_load = req0 | req1;
                tmr_val  = LD_SETUP;
            end
            BF_SETUP, WR_SETUP: begin
                tmr_load = tmr_done;
                tmr_val  = LD_EN;
            end
            BF_EN, WR_EN: begin
                tmr_load = tmr_done;
                tmr_val  = LD_HOLD;
            end
            BF_GAP: begin
                tmr_load = tmr_done;
                tmr_val  = go_wr ? LD_WRSET : LD_SETUP;
            end
            default: ;
        endcase
    end

    lcd_phase_timer #(.W(CNT_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .cnt_o  (tmr_cnt),
        .done_o (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_last_q  <= 1'b1;
            gnt1_q     <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= '0;
            bf_q       <= 1'b0;
            poll_q     <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_rw_q   <= 1'b0;
            lcd_en_q   <= 1'b0;
            lcd_on_q   <= 1'b0;
            lcd_oe_q   <= 1'b0;
            lcd_dout_q <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            lcd_on_q <= 1'b1;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            if (state_q inside {BF_SETUP, BF_EN, BF_GAP} && poll_q != '1)
                poll_q <= poll_q + 1'b1;
            case (state_q)
                IDLE: if (req0 | req1) begin
                    gnt1_q    <= !gnt0;
                    rr_last_q <= !gnt0;
                    rs_q      <= gnt0 ? rs0 : rs1;
                    data_q    <= gnt0 ? data0 : data1;
                    poll_q    <= '0;
                    lcd_rs_q  <= 1'b0;
                    lcd_rw_q  <= 1'b1;
                    lcd_oe_q  <= 1'b0;
                    lcd_en_q  <= 1'b0;
                    state_q   <= BF_SETUP;
                end
                BF_SETUP: if (tmr_done) begin
                    lcd_en_q <= 1'b1;
                    state_q  <= BF_EN;
                end
                BF_EN: if (tmr_done) begin
                    lcd_en_q <= 1'b0;
                    bf_q     <= lcd_din[7];
                    state_q  <= BF_GAP;
                end
                BF_GAP: if (tmr_done) begin
                    if (bf_q && poll_hit)
                        timeout_q <= 1'b1;
                    if (go_wr)
                        lcd_rw_q <= 1'b0;
                    state_q <= go_wr ? WR_SETUP : BF_SETUP;
                end
                WR_SETUP: begin
                    // First cycle only turns RW around; the bus is driven from the next one.
                    if (tmr_cnt == LD_WRSET) begin
                        lcd_oe_q   <= 1'b1;
                        lcd_rs_q   <= rs_q;
                        lcd_dout_q <= data_q;
                    end
                    if (tmr_done) begin
                        lcd_en_q <= 1'b1;
                        state_q  <= WR_EN;
                    end
                end
                WR_EN: if (tmr_done) begin
                    lcd_en_q <= 1'b0;
                    state_q  <= WR_HOLD;
                end
                WR_HOLD: if (tmr_done) begin
                    lcd_oe_q <= 1'b0;
                    ack0_q   <= !gnt1_q;
                    ack1_q   <= gnt1_q;
                    state_q  <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_rw      = lcd_rw_q;
    assign lcd_en      = lcd_en_q;
    assign lcd_on      = lcd_on_q;
    assign lcd_oe      = lcd_oe_q;
    assign lcd_dout    = lcd_dout_q;
    assign busy        = state_q != IDLE;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// tb_lcd_bus_arbiter: directed scenarios for the LCD bus arbiter plus a continuous bus-protocol monitor.
module tb_lcd_bus_arbiter;

    localparam int T_SETUP = 4;
    localparam int T_HOLD  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
    logic [7:0] data0 = '0, data1 = '0, lcd_din = '0;
    logic       ack0, ack1, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_oe, busy, timeout_err;
    logic [7:0] lcd_dout;

    int passed = 0;
    int total  = 0;

    int         busy_polls = 0;
    int         bf_pulses, wr_pulses, bf_en_cyc, wr_en_cyc, ack_at;
    bit         ack_seq[$];
    logic [8:0] wr_seq[$];

    lcd_bus_arbiter #(.BF_TIMEOUT(100)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0        (req0),
        .rs0         (rs0),
        .data0       (data0),
        .ack0        (ack0),
        .req1        (req1),
        .rs1         (rs1),
        .data1       (data1),
        .ack1        (ack1),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_en      (lcd_en),
        .lcd_on      (lcd_on),
        .lcd_oe      (lcd_oe),
        .lcd_dout    (lcd_dout),
        .lcd_din     (lcd_din),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Bus protocol monitor: oe/rw exclusion, single ack, RS/RW/OE/dout setup and hold around E.
    logic [10:0] mon_prev = '0;
    logic        mon_en_prev = 1'b0;
    int          mon_stable = 0;
    int          mon_fall = 99;
    always @(negedge clk) begin
        logic chg;
        if (rst !== 1'b1) begin
            mon_stable = 0;
            mon_fall   = 99;
        end else begin
            chg = {lcd_rs, lcd_rw, lcd_oe, lcd_dout} !== mon_prev;
            total++;
            if (lcd_oe && lcd_rw) $display("FAIL mon_oe_rw: oe=%b rw=%b required not both 1", lcd_oe, lcd_rw);
            else passed++;
            total++;
            if (ack0 && ack1) $display("FAIL mon_ack_both: ack0=%b ack1=%b required not both 1", ack0, ack1);
            else passed++;
            total++;
            if (lcd_en && (chg || (!mon_en_prev && mon_stable < T_SETUP)))
                $display("FAIL mon_setup: chg=%b stable=%0d required no change and >=%0d", chg, mon_stable, T_SETUP);
            else if (!lcd_en && chg && mon_fall < T_HOLD)
                $display("FAIL mon_hold: cycles after E fall=%0d required >=%0d", mon_fall, T_HOLD);
            else passed++;
            mon_stable = chg ? 1 : mon_stable + 1;
            mon_fall   = lcd_en ? 0 : (mon_fall < 99 ? mon_fall + 1 : 99);
        end
        mon_prev    = {lcd_rs, lcd_rw, lcd_oe, lcd_dout};
        mon_en_prev = lcd_en;
    end

    // Stimulus helper: runs cycles 2..ncyc after the grant cycle and records bus activity.
    task automatic watch(input int ncyc, input int drop_after);
        logic en_p = 1'b0;
        bf_pulses = 0; wr_pulses = 0; bf_en_cyc = 0; wr_en_cyc = 0; ack_at = 0;
        ack_seq.delete();
        wr_seq.delete();
        for (int n = 2; n <= ncyc; n++) begin
            @(negedge clk);
            if (lcd_en && !en_p) begin
                if (lcd_rw) bf_pulses++;
                else begin
                    wr_pulses++;
                    wr_seq.push_back({lcd_rs, lcd_dout});
                end
            end
            if (lcd_en) begin
                if (lcd_rw) bf_en_cyc++;
                else wr_en_cyc++;
            end
            if (en_p && !lcd_en && lcd_rw && bf_pulses >= busy_polls) lcd_din = 8'h00;
            if (ack0 || ack1) begin
                if (ack_at == 0) ack_at = n;
                ack_seq.push_back(ack1);
                if (ack_seq.size() == drop_after) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
            en_p = lcd_en;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_oe, lcd_dout, busy, timeout_err, ack0, ack1} !== 17'h0)
            $display("FAIL reset_outputs: got %b required all 0",
                     {lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_oe, lcd_dout, busy, timeout_err, ack0, ack1});
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (lcd_on !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release: lcd_on=%b busy=%b required 1 0", lcd_on, busy);
        else passed++;
    endtask

    task automatic test_single();
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h50; lcd_din = 8'h00; busy_polls = 0;
        watch(60, 1);
        total++;
        if (ack_at !== 43) $display("FAIL single_ack_cycle: got %0d required 43", ack_at);
        else passed++;
        total++;
        if (ack_seq.size() !== 1 || ack_seq[0] !== 1'b0) $display("FAIL single_ack_count: got %0d acks first=%b required 1 ack0", ack_seq.size(), ack_seq[0]);
        else passed++;
        total++;
        if (bf_pulses !== 1 || bf_en_cyc !== 12) $display("FAIL single_bf_read: pulses=%0d en_cycles=%0d required 1 12", bf_pulses, bf_en_cyc);
        else passed++;
        total++;
        if (wr_pulses !== 1 || wr_en_cyc !== 12) $display("FAIL single_write_en: pulses=%0d en_cycles=%0d required 1 12", wr_pulses, wr_en_cyc);
        else passed++;
        total++;
        if (wr_seq[0] !== 9'h150) $display("FAIL single_write_data: got %h required 150", wr_seq[0]);
        else passed++;
        total++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) $display("FAIL single_idle: busy=%b timeout_err=%b required 0 0", busy, timeout_err);
        else passed++;
    endtask

    task automatic test_round_robin();
        pulse_reset();
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h50;
        req1 = 1'b1; rs1 = 1'b0; data1 = 8'h38;
        watch(180, 4);
        total++;
        if (ack_at !== 43) $display("FAIL rr_first_ack: got %0d required 43", ack_at);
        else passed++;
        total++;
        if (ack_seq.size() !== 4 || {ack_seq[0], ack_seq[1], ack_seq[2], ack_seq[3]} !== 4'b0101)
            $display("FAIL rr_order: got %0d acks %b%b%b%b required 4 acks 0101",
                     ack_seq.size(), ack_seq[0], ack_seq[1], ack_seq[2], ack_seq[3]);
        else passed++;
        total++;
        if (wr_seq.size() !== 4 || wr_seq[0] !== 9'h150 || wr_seq[1] !== 9'h038)
            $display("FAIL rr_data: got %0d writes %h %h required 4 writes 150 038", wr_seq.size(), wr_seq[0], wr_seq[1]);
        else passed++;
    endtask

    task automatic test_busy_polls();
        lcd_din = 8'h80; busy_polls = 3;
        req0 = 1'b1; rs0 = 1'b0; data0 = 8'h01;
        watch(120, 1);
        total++;
        if (bf_pulses !== 4 || wr_pulses !== 1) $display("FAIL polls_pulses: bf=%0d wr=%0d required 4 1", bf_pulses, wr_pulses);
        else passed++;
        total++;
        if (ack_at !== 103) $display("FAIL polls_ack_cycle: got %0d required 103", ack_at);
        else passed++;
        total++;
        if (timeout_err !== 1'b0 || wr_seq[0] !== 9'h001) $display("FAIL polls_result: timeout_err=%b data=%h required 0 001", timeout_err, wr_seq[0]);
        else passed++;
    endtask

    task automatic test_timeout();
        lcd_din = 8'h80; busy_polls = 1000;
        req1 = 1'b1; rs1 = 1'b0; data1 = 8'hC0;
        watch(140, 1);
        total++;
        if (bf_pulses !== 5 || ack_at !== 123) $display("FAIL timeout_polls: bf=%0d ack_cycle=%0d required 5 123", bf_pulses, ack_at);
        else passed++;
        total++;
        if (timeout_err !== 1'b1 || wr_seq[0] !== 9'h0C0 || ack_seq[0] !== 1'b1)
            $display("FAIL timeout_write: timeout_err=%b data=%h ack1=%b required 1 0c0 1", timeout_err, wr_seq[0], ack_seq[0]);
        else passed++;
        lcd_din = 8'h00; busy_polls = 0;
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
        watch(60, 1);
        total++;
        if (ack_at !== 43 || timeout_err !== 1'b1) $display("FAIL timeout_sticky: ack_cycle=%0d timeout_err=%b required 43 1", ack_at, timeout_err);
        else passed++;
    endtask

    task automatic test_reset_mid_write();
        int acks = 0;
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h5A;
        for (int n = 2; n <= 30; n++) @(negedge clk);
        total++;
        if (lcd_en !== 1'b1 || lcd_oe !== 1'b1 || lcd_rw !== 1'b0) $display("FAIL midrst_in_wr_en: en=%b oe=%b rw=%b required 1 1 0", lcd_en, lcd_oe, lcd_rw);
        else passed++;
        rst = 1'b0; req0 = 1'b0;
        @(negedge clk);
        total++;
        if ({lcd_en, lcd_oe, busy, ack0, ack1, timeout_err} !== 6'b0)
            $display("FAIL midrst_outputs: en,oe,busy,ack0,ack1,terr=%b required 000000", {lcd_en, lcd_oe, busy, ack0, ack1, timeout_err});
        else passed++;
        rst = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        total++;
        if (acks !== 0) $display("FAIL midrst_no_ack: got %0d acks required 0", acks);
        else passed++;
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h5A;
        watch(60, 1);
        total++;
        if (ack_at !== 43 || wr_seq[0] !== 9'h15A) $display("FAIL midrst_recover: ack_cycle=%0d data=%h required 43 15a", ack_at, wr_seq[0]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy_polls();
        test_timeout();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
Shares the single HD44780-style character-LCD bus between two requesters, for example the power-on init sequencer and a text/cursor writer. Before every write it polls the busy flag (DB7), then sequences the RS/RW/E/data timing with internal counters. It replaces ad-hoc per-state delay timers with one reusable transaction engine. It sits between the requesters and the top-level LCD pins; the tristate is resolved at top level from lcd_oe.

Parameters:
T_SETUP, 4, clk cycles RS/RW/data stable before E rises (≥ 60 ns at 50 MHz)
T_EN, 12, clk cycles E held high (≥ 230 ns)
T_HOLD, 4, clk cycles after E falls before RS/RW/data/oe may change
BF_TIMEOUT, 200000, max clk cycles spent polling busy before forcing the write
CNT_W, 18, width of the shared timing counter (must hold BF_TIMEOUT)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
req0  in  1  requester 0 transaction request, level, held until ack0
rs0  in  1  requester 0 register select (0 = command, 1 = data)
data0  in  8  requester 0 byte
ack0  out  1  one-cycle pulse when requester 0 write completes
req1  in  1  requester 1 request
rs1  in  1  requester 1 register select
data1  in  8  requester 1 byte
ack1  out  1  one-cycle completion pulse for requester 1
lcd_rs  out  1  LCD RS
lcd_rw  out  1  LCD RW (1 = read)
lcd_en  out  1  LCD E
lcd_on  out  1  LCD power/backlight enable
lcd_oe  out  1  1 = FPGA drives data bus
lcd_dout  out  8  bus drive value
lcd_din  in  8  sampled bus value (already synchronised at top level)
busy  out  1  transaction in progress (state != IDLE)
timeout_err  out  1  sticky: a busy poll hit BF_TIMEOUT

Behaviour:
- Reset (rst==0 at clk edge): all outputs 0, state IDLE, counters 0, rr_last=1 so requester 0 wins first. lcd_on goes 1 on the first cycle after reset release and stays 1.
- Arbitration in IDLE: round-robin on a single request. Grant goes to the only requester asserting. If both assert, grant goes to the one not in rr_last. On grant, latch rs/data into internal registers and update rr_last. Requester inputs are ignored after the latch.
- State machine; the counter reloads on every state entry:
  - IDLE: on grant -> BF_SETUP.
  - BF_SETUP: rs=0, rw=1, oe=0, en=0 for T_SETUP -> BF_EN.
  - BF_EN: en=1 for T_EN. On the last cycle, sample lcd_din[7]; then en=0 -> BF_GAP.
  - BF_GAP: hold T_HOLD cycles.
    - If the sampled DB7 is 0 -> WR_SETUP.
    - Else if the poll cycle total ≥ BF_TIMEOUT, set timeout_err -> WR_SETUP.
    - Else -> BF_SETUP.
    - The poll total is counted by a separate accumulator, cleared on grant.
  - WR_SETUP:
    - Cycle 0: rw=0 with oe still 0 (bus turnaround).
    - Cycle 1 onward: oe=1, rs=latched rs, dout=latched data.
    - Total T_SETUP+1 cycles -> WR_EN.
  - WR_EN: en=1 for T_EN -> WR_HOLD.
  - WR_HOLD: en=0, rs/rw/dout/oe held for T_HOLD. Then oe=0 -> DONE.
  - DONE: pulse ack of the granted requester for exactly 1 cycle -> IDLE.
- Minimum transaction with busy clear: 3 + 3*T_SETUP... fixed: (T_SETUP+T_EN+T_HOLD)*2 + 1 + 2 cycles = 43 clk with defaults (grant edge to ack inclusive).
- Requester rule: deassert req the cycle after ack, or issue the next request. A req still high in IDLE after ack is treated as a new transaction.
- Invariants:
  - lcd_oe=1 never coincides with lcd_rw=1.
  - lcd_en never rises in the same cycle RS/RW/dout change.
  - ack0 and ack1 are never both high.
- Reset mid-transaction: all outputs go to reset values on the same edge, including en and oe dropping. No ack is issued for the aborted request.
- Counter wrap: counters saturate and never wrap. BF_TIMEOUT > 2^CNT_W-1 is illegal; this is a static check.

Decomposition:
- Package lcd_pkg holds:
  - the state enum;
  - HD44780 command constants (CLEAR=8'h01, ENTRY_INC=8'h06, DISP_ON_CUR=8'h0E, FUNC_SET_8B2L=8'h38, LINE2_ADDR=8'hC0);
  - default timing constants.
- One natural sub-module, lcd_phase_timer: a loadable down-counter with a done flag, shared by all timed states.

Test Plan:
- Single req0, rs0=1, data0=8'h50, lcd_din[7]=0 throughout -> one BF read (rw=1, oe=0, en high 12 cycles), then write with rs=1, dout=8'h50, en high 12 cycles; ack0 pulses once 43 cycles after grant; ack1 stays 0.
- req0 and req1 asserted in the same cycle after reset -> requester 0 served first, then requester 1; with both held continuously, grants alternate 0,1,0,1.
- lcd_din[7]=1 for 3 polls, then 0 -> exactly 4 BF_EN pulses precede the write enable pulse; timeout_err stays 0.
- lcd_din[7] stuck at 1, BF_TIMEOUT=100 -> write issued after ≥100 poll cycles; timeout_err=1 and stays 1 through later clean transactions until rst=0.
- rst=0 asserted during WR_EN -> next cycle lcd_en=0, lcd_oe=0, busy=0, no ack; a subsequent request completes normally.
- Bus checker over all tests: never oe=1 with rw=1; RS/dout stable from T_SETUP before E rise through T_HOLD after E fall.
